led_out_pio: RTL

Avalon-MM slave output PIO, the write-side counterpart of the board input-port slaves. It drives board LEDs/outputs from CPU writes, with atomic set/clear addresses. A per-bit hardware blink mask toggles selected bits from an internal prescaler, so the CPU does not poll timers. Readback of every register is via the same 1-cycle registered readdata path as the input ports.

---
 rtl/led_pio_pkg.sv | 14 +
 rtl/led_out_pio_if.sv | 23 ++
 rtl/blink_prescaler.sv | 33 +++
 rtl/led_out_pio.sv | 66 ++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared register-map definitions for the board PIO slaves.
// The input-port slaves reuse ADDR_DATA.
package led_pio_pkg;

    localparam int ADDR_W = 2;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ADDR_DATA  = 2'd0;
    localparam addr_t ADDR_BLINK = 2'd1;
    localparam addr_t ADDR_SET   = 2'd2;
    localparam addr_t ADDR_CLR   = 2'd3;

endpackage

// File: rtl/led_out_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The CPU side takes the master modport and the PIO takes the slave modport.
interface led_out_pio_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [led_pio_pkg::ADDR_W-1:0] address;
    logic                           chipselect;
    logic                           write_n;
    logic [DATA_WIDTH-1:0]          writedata;
    logic [DATA_WIDTH-1:0]          readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/blink_prescaler.sv
// Free-running divider that toggles phase once every DIV clock cycles.
// A restart pulse returns it to count 0, phase 0, and overrides a wrap in the same cycle.
module blink_prescaler #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_out_pio.sv
// Avalon-MM output PIO with DATA/BLINK_MASK registers and atomic set/clear addresses.
// Masked bits are forced low while the prescaler phase is 1.
module led_out_pio
    import led_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    led_out_pio_if.slave          bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] blink_mask;
    logic [DATA_WIDTH-1:0] read_mux;
    logic                  wr_en;
    logic                  blink_phase;

    assign wr_en = bus.chipselect & ~bus.write_n;

    blink_prescaler #(
        .DIV (BLINK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (wr_en && (bus.address == ADDR_BLINK)),
        .phase   (blink_phase)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg   <= RESET_VALUE;
            blink_mask <= '0;
        end else if (wr_en) begin
            unique case (bus.address)
                ADDR_DATA:  data_reg   <= bus.writedata;
                ADDR_BLINK: blink_mask <= bus.writedata;
                ADDR_SET:   data_reg   <= data_reg | bus.writedata;
                ADDR_CLR:   data_reg   <= data_reg & ~bus.writedata;
            endcase
        end
    end

    assign out_port = data_reg & ~(blink_mask & {DATA_WIDTH{blink_phase}});

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        read_mux = '0;
        unique case (bus.address)
            ADDR_DATA:  read_mux = data_reg;
            ADDR_BLINK: read_mux = blink_mask;
            ADDR_SET:   read_mux = out_port;
            ADDR_CLR:   read_mux = '0;
        endcase
    end

    // Sampled every cycle, so a read that coincides with a write returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= read_mux;
    end

endmodule
